// File: rtl/algo_4ror1w_req_sched.sv
// Request scheduler for a 4-read/1-write core: arbitrates per-port reads, one
// buffered write and periodic refresh slots onto registered core strobes.
module algo_4ror1w_req_sched #(
  parameter int WIDTH     = 64,
  parameter int BITADDR   = 13,
  parameter int REFRESH   = 1,
  parameter int REFFREQ   = 6,
  parameter int WRMAXWAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready,
  input  logic [3:0]           up_read,
  input  logic [4*BITADDR-1:0] up_rd_adr,
  output logic [3:0]           up_rd_ack,
  input  logic                 up_write,
  input  logic [BITADDR-1:0]   up_wr_adr,
  input  logic [WIDTH-1:0]     up_din,
  output logic                 up_wr_rdy,
  output logic [3:0]           read,
  output logic [4*BITADDR-1:0] rd_adr,
  output logic                 write,
  output logic [BITADDR-1:0]   wr_adr,
  output logic [WIDTH-1:0]     din,
  output logic                 refr
);

  localparam int CW = $clog2(REFFREQ);
  localparam int WW = $clog2(WRMAXWAIT + 1);
  localparam logic [CW-1:0] RLAST = CW'(REFFREQ - 1);
  localparam logic [WW-1:0] WMAX  = WW'(WRMAXWAIT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_rcnt;
  logic [WW-1:0]        r_wage;
  logic                 r_bvalid;
  logic [BITADDR-1:0]   r_badr;
  logic [WIDTH-1:0]     r_bdata;

  logic                 w_run;
  logic                 w_refslot;
  logic                 w_wrsel;
  logic                 w_rdsel;
  logic                 w_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_INIT;
    else      r_state <= w_state_nxt;
  end

  // A RUN cycle with ready low grants nothing; arbitration only happens when
  // the core is both in RUN and still reporting ready.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_refslot   = 1'b0;
    w_wrsel     = 1'b0;
    w_rdsel     = 1'b0;
    up_rd_ack   = '0;
    up_wr_rdy   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (ready) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        up_wr_rdy = !r_bvalid;
        if (!ready) begin
          w_state_nxt = ST_INIT;
        end else begin
          w_run     = 1'b1;
          w_refslot = (REFRESH != 0) && (r_rcnt == RLAST);
          if (!w_refslot) begin
            w_wrsel = r_bvalid && ((up_read == 4'b0000) || (r_wage >= WMAX));
            w_rdsel = !w_wrsel;
          end
          if (w_rdsel) up_rd_ack = up_read;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_load = up_write && up_wr_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rcnt <= '0;
    end else if (w_run) begin
      r_rcnt <= (r_rcnt == RLAST) ? '0 : r_rcnt + CW'(1);
    end else begin
      r_rcnt <= '0;
    end
  end

  // Write age only advances while a buffered write is actually being held off
  // by granted reads; refresh slots leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wage <= '0;
    end else if (!w_run || w_wrsel) begin
      r_wage <= '0;
    end else if (w_rdsel && r_bvalid && (up_read != 4'b0000) && (r_wage != WMAX)) begin
      r_wage <= r_wage + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bvalid <= 1'b0;
      r_badr   <= '0;
      r_bdata  <= '0;
    end else if (w_load) begin
      r_bvalid <= 1'b1;
      r_badr   <= up_wr_adr;
      r_bdata  <= up_din;
    end else if (w_wrsel) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read   <= '0;
      rd_adr <= '0;
      write  <= 1'b0;
      wr_adr <= '0;
      din    <= '0;
      refr   <= 1'b0;
    end else begin
      read  <= w_rdsel ? up_read : 4'b0000;
      write <= w_wrsel;
      refr  <= w_refslot;
      if (w_rdsel) rd_adr <= up_rd_adr;
      if (w_wrsel) begin
        wr_adr <= r_badr;
        din    <= r_bdata;
      end
    end
  end

endmodule

// File: tb/tb_algo_4ror1w_req_sched.sv
// Directed bench for algo_4ror1w_req_sched: refresh cadence, read grants,
// write latency, write ageing, ready outage and mid-operation reset.
module tb_algo_4ror1w_req_sched;

  localparam int W  = 64;
  localparam int BA = 13;
  localparam logic [4*BA-1:0] ADRS = {13'd4, 13'd3, 13'd2, 13'd1};

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic [3:0]      up_read;
  logic [4*BA-1:0] up_rd_adr;
  logic [3:0]      up_rd_ack;
  logic            up_write;
  logic [BA-1:0]   up_wr_adr;
  logic [W-1:0]    up_din;
  logic            up_wr_rdy;
  logic [3:0]      read;
  logic [4*BA-1:0] rd_adr;
  logic            write;
  logic [BA-1:0]   wr_adr;
  logic [W-1:0]    din;
  logic            refr;

  int checks = 0;
  int errors = 0;

  algo_4ror1w_req_sched #(
    .WIDTH(W), .BITADDR(BA), .REFRESH(1), .REFFREQ(6), .WRMAXWAIT(4)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .up_read(up_read), .up_rd_adr(up_rd_adr), .up_rd_ack(up_rd_ack),
    .up_write(up_write), .up_wr_adr(up_wr_adr), .up_din(up_din), .up_wr_rdy(up_wr_rdy),
    .read(read), .rd_adr(rd_adr), .write(write), .wr_adr(wr_adr), .din(din), .refr(refr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read"}, 64'(read), 64'd0);
    chk({tag, "_write"}, 64'(write), 64'd0);
    chk({tag, "_refr"}, 64'(refr), 64'd0);
    chk({tag, "_rdadr"}, 64'(rd_adr), 64'd0);
    chk({tag, "_wradr"}, 64'(wr_adr), 64'd0);
    chk({tag, "_din"}, din, 64'd0);
    chk({tag, "_ack"}, 64'(up_rd_ack), 64'd0);
    chk({tag, "_wrrdy"}, 64'(up_wr_rdy), 64'd0);
  endtask

  initial begin
    logic [3:0] exp_ack;
    logic [3:0] age_ack [7];
    age_ack = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0};

    rst = 1'b0; ready = 1'b0; up_read = '0; up_rd_adr = ADRS;
    up_write = 1'b0; up_wr_adr = '0; up_din = '0;
    #3;
    chk_zero("rst0");
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst1");

    // Refresh cadence with no traffic
    rst = 1'b1; ready = 1'b1;
    tick();
    chk("run_wrrdy", 64'(up_wr_rdy), 64'd1);
    chk("run_refr0", 64'(refr), 64'd0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("idle_refr", 64'(refr), (i % 6 == 0) ? 64'd1 : 64'd0);
      chk("idle_read", 64'(read), 64'd0);
      chk("idle_write", 64'(write), 64'd0);
    end

    // Held reads 1011, counter starts this cycle at 0
    up_read = 4'b1011;
    for (int j = 0; j < 8; j++) begin
      #1;
      exp_ack = (j % 6 == 5) ? 4'b0000 : 4'b1011;
      chk("rd_ack", 64'(up_rd_ack), 64'(exp_ack));
      tick();
      chk("rd_read", 64'(read), 64'(exp_ack));
      chk("rd_refr", 64'(refr), (j % 6 == 5) ? 64'd1 : 64'd0);
      chk("rd_adr", 64'(rd_adr), 64'(ADRS));
      chk("rd_write", 64'(write), 64'd0);
    end

    // Single write with no reads: counter at 2
    up_read = 4'b0000;
    up_write = 1'b1; up_wr_adr = 13'h55; up_din = 64'hA5;
    #1;
    chk("wr_rdy_pre", 64'(up_wr_rdy), 64'd1);
    tick();
    up_write = 1'b0;
    chk("wr_rdy_held", 64'(up_wr_rdy), 64'd0);
    chk("wr_early", 64'(write), 64'd0);
    chk("wr_read0", 64'(read), 64'd0);
    tick();
    chk("wr_issue", 64'(write), 64'd1);
    chk("wr_adr", 64'(wr_adr), 64'h55);
    chk("wr_din", din, 64'hA5);
    chk("wr_noread", 64'(read), 64'd0);
    chk("wr_rdy_post", 64'(up_wr_rdy), 64'd1);
    tick();
    chk("wr_single", 64'(write), 64'd0);

    // Write ageing under continuous reads; this cycle is a refresh slot
    up_read = 4'hF;
    #1;
    chk("age_slot_ack", 64'(up_rd_ack), 64'd0);
    tick();
    chk("age_slot_refr", 64'(refr), 64'd1);
    chk("age_slot_read", 64'(read), 64'd0);
    #1;
    chk("age_pre_ack", 64'(up_rd_ack), 64'hF);
    tick();
    chk("age_pre_read", 64'(read), 64'hF);
    up_write = 1'b1; up_wr_adr = 13'h77; up_din = 64'h1234;
    for (int m = 0; m < 7; m++) begin
      #1;
      chk("age_ack", 64'(up_rd_ack), 64'(age_ack[m]));
      chk("age_wrrdy", 64'(up_wr_rdy), (m == 0) ? 64'd1 : 64'd0);
      tick();
      if (m == 0) up_write = 1'b0;
      chk("age_read", 64'(read), 64'(age_ack[m]));
      chk("age_write", 64'(write), (m == 6) ? 64'd1 : 64'd0);
      chk("age_refr", 64'(refr), (m == 4) ? 64'd1 : 64'd0);
    end
    chk("age_wradr", 64'(wr_adr), 64'h77);
    chk("age_din", din, 64'h1234);

    // Ready outage with a write buffered behind reads
    up_write = 1'b1; up_wr_adr = 13'h3C; up_din = 64'h99;
    #1;
    chk("out_wrrdy", 64'(up_wr_rdy), 64'd1);
    chk("out_ack", 64'(up_rd_ack), 64'hF);
    tick();
    up_write = 1'b0;
    chk("out_read", 64'(read), 64'hF);
    ready = 1'b0;
    #1;
    chk("out_fall_ack", 64'(up_rd_ack), 64'd0);
    chk("out_fall_wrrdy", 64'(up_wr_rdy), 64'd0);
    for (int o = 0; o < 3; o++) begin
      tick();
      chk("out_read0", 64'(read), 64'd0);
      chk("out_write0", 64'(write), 64'd0);
      chk("out_refr0", 64'(refr), 64'd0);
      chk("out_ack0", 64'(up_rd_ack), 64'd0);
    end
    ready = 1'b1; up_read = 4'b0000;
    tick();
    chk("ret_init_write", 64'(write), 64'd0);
    chk("ret_init_read", 64'(read), 64'd0);
    tick();
    chk("ret_write", 64'(write), 64'd1);
    chk("ret_wradr", 64'(wr_adr), 64'h3C);
    chk("ret_din", din, 64'h99);

    // Reset while a write is buffered and reads are active
    up_read = 4'b0101; up_write = 1'b1; up_wr_adr = 13'h11; up_din = 64'h22;
    #1;
    chk("mr_ack", 64'(up_rd_ack), 64'h5);
    tick();
    up_write = 1'b0;
    chk("mr_read", 64'(read), 64'h5);
    #1;
    chk("mr_wrrdy", 64'(up_wr_rdy), 64'd0);
    #1;
    rst = 1'b0;
    #1;
    chk_zero("mr_rst");
    @(negedge clk);
    up_read = 4'b0000;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mr_nowrite", 64'(write), 64'd0);
      chk("mr_refr", 64'(refr), (i == 6) ? 64'd1 : 64'd0);
      chk("mr_wrrdy_post", 64'(up_wr_rdy), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
